// File: rtl/mc_pkg.sv
// Shared definitions for the missionaries-and-cannibals move sequencer.
// Holds the FSM state encoding, the response codes and the starting bank counts.
package mc_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_APPLY = 3'd2,
    S_RESP  = 3'd3,
    S_DONE  = 3'd4,
    S_LOST  = 3'd5
  } state_t;

  localparam logic [1:0] RESP_OK      = 2'b00;
  localparam logic [1:0] RESP_ILLEGAL = 2'b01;
  localparam logic [1:0] RESP_UNSAFE  = 2'b10;
  localparam logic [1:0] RESP_WIN     = 2'b11;

  localparam logic [1:0] INIT_M = 2'd3;
  localparam logic [1:0] INIT_C = 2'd3;

endpackage

// File: rtl/mc_move_checker.sv
// Combinational move classifier.
// Ports:
//   m_left, c_left     : current counts on the original (left) bank
//   boat_side          : 0 = boat on left bank, 1 = boat on right bank
//   req_m, req_c       : people requested on the boat
//   code               : RESP_OK / RESP_ILLEGAL / RESP_UNSAFE / RESP_WIN
//   next_m_left/c_left : left-bank counts after the move (meaningful only for OK/WIN)
module mc_move_checker
  import mc_pkg::*;
(
  input  logic [1:0] m_left,
  input  logic [1:0] c_left,
  input  logic       boat_side,
  input  logic [1:0] req_m,
  input  logic [1:0] req_c,
  output logic [1:0] code,
  output logic [1:0] next_m_left,
  output logic [1:0] next_c_left
);

  logic [2:0] total;
  logic [1:0] src_m, src_c;
  logic [1:0] right_m, right_c;
  logic       illegal, unsafe, win;

  always_comb begin
    total = {1'b0, req_m} + {1'b0, req_c};
    // People available are those on the bank where the boat currently sits.
    src_m = boat_side ? (INIT_M - m_left) : m_left;
    src_c = boat_side ? (INIT_C - c_left) : c_left;
    illegal = (total == 3'd0) || (total > 3'd2) || (req_m > src_m) || (req_c > src_c);

    // Leaving the left bank removes people from it; returning adds them back.
    next_m_left = boat_side ? (m_left + req_m) : (m_left - req_m);
    next_c_left = boat_side ? (c_left + req_c) : (c_left - req_c);
    right_m = INIT_M - next_m_left;
    right_c = INIT_C - next_c_left;

    unsafe = ((next_m_left != 2'd0) && (next_m_left < next_c_left)) ||
             ((right_m != 2'd0) && (right_m < right_c));
    win = (next_m_left == 2'd0) && (next_c_left == 2'd0) && !boat_side;

    code = RESP_OK;
    if (illegal)     code = RESP_ILLEGAL;
    else if (unsafe) code = RESP_UNSAFE;
    else if (win)    code = RESP_WIN;
  end

endmodule

// File: rtl/mc_move_sequencer.sv
// Missionaries-and-cannibals move sequencer: accepts one boat move per
// handshake, classifies it, applies legal moves and returns a response
// strobe three cycles after the handshake.
// Ports:
//   clock, reset (sync, active-low), restart (sync game restart)
//   req_valid/req_ready/req_m/req_c : move request handshake
//   resp_valid/resp_code            : one-cycle response
//   missionary_left, cannibal_left, boat_side, move_count : game state
//   finish (DONE), lost (LOST)
//
// state | meaning
// ------+------------------------------------------------
// IDLE  | waiting for a move, req_ready high
// CHECK | classify latched move
// APPLY | update banks/boat/count for OK or WIN
// RESP  | resp_valid strobe with the move's code
// DONE  | game won, holds until restart/reset
// LOST  | move limit reached, holds until restart/reset
module mc_move_sequencer
  import mc_pkg::*;
#(
  parameter logic [4:0] MOVE_LIMIT = 5'd20
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       restart,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_m,
  input  logic [1:0] req_c,
  output logic       resp_valid,
  output logic [1:0] resp_code,
  output logic [1:0] missionary_left,
  output logic [1:0] cannibal_left,
  output logic       boat_side,
  output logic [4:0] move_count,
  output logic       finish,
  output logic       lost
);

  state_t     state, state_next;
  logic [1:0] lat_m, lat_c;
  logic [1:0] move_code;
  logic [1:0] chk_code, chk_m_left, chk_c_left;
  logic       accepted;

  mc_move_checker u_checker (
    .m_left      (missionary_left),
    .c_left      (cannibal_left),
    .boat_side   (boat_side),
    .req_m       (lat_m),
    .req_c       (lat_c),
    .code        (chk_code),
    .next_m_left (chk_m_left),
    .next_c_left (chk_c_left)
  );

  assign req_ready = (state == S_IDLE);
  assign accepted  = (move_code == RESP_OK) || (move_code == RESP_WIN);

  always_comb begin
    state_next = state;
    if (restart) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (req_valid) state_next = S_CHECK;
        S_CHECK: state_next = S_APPLY;
        S_APPLY: state_next = S_RESP;
        S_RESP: begin
          if (move_code == RESP_WIN)
            state_next = S_DONE;
          else if ((move_code == RESP_OK) && (move_count == MOVE_LIMIT))
            state_next = S_LOST;
          else
            state_next = S_IDLE;
        end
        S_DONE:  state_next = S_DONE;
        S_LOST:  state_next = S_LOST;
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset || restart) begin
      state           <= S_IDLE;
      lat_m           <= 2'd0;
      lat_c           <= 2'd0;
      move_code       <= RESP_OK;
      missionary_left <= INIT_M;
      cannibal_left   <= INIT_C;
      boat_side       <= 1'b0;
      move_count      <= 5'd0;
      resp_valid      <= 1'b0;
      resp_code       <= RESP_OK;
      finish          <= 1'b0;
      lost            <= 1'b0;
    end else begin
      state <= state_next;
      if (state == S_IDLE && req_valid) begin
        lat_m <= req_m;
        lat_c <= req_c;
      end
      if (state == S_CHECK) move_code <= chk_code;
      // Bank counts are untouched between CHECK and APPLY, so the checker's
      // next counts are still valid here.
      if (state == S_APPLY && accepted) begin
        missionary_left <= chk_m_left;
        cannibal_left   <= chk_c_left;
        boat_side       <= ~boat_side;
        if (move_count != 5'd31) move_count <= move_count + 5'd1;
      end
      // Outputs are registered from the next state so they line up with it.
      resp_valid <= (state_next == S_RESP);
      resp_code  <= (state_next == S_RESP) ? move_code : RESP_OK;
      finish     <= (state_next == S_DONE);
      lost       <= (state_next == S_LOST);
    end
  end

endmodule

// File: tb/tb_mc_move_sequencer.sv
module tb_mc_move_sequencer;
  import mc_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic       restart;
  logic       req_valid;
  logic [1:0] req_m, req_c;

  logic       req_ready, resp_valid, boat_side, finish, lost;
  logic [1:0] resp_code, missionary_left, cannibal_left;
  logic [4:0] move_count;

  logic       l_req_ready, l_resp_valid, l_boat_side, l_finish, l_lost;
  logic [1:0] l_resp_code, l_missionary_left, l_cannibal_left;
  logic [4:0] l_move_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  mc_move_sequencer dut (
    .clock(clock), .reset(reset), .restart(restart),
    .req_valid(req_valid), .req_ready(req_ready), .req_m(req_m), .req_c(req_c),
    .resp_valid(resp_valid), .resp_code(resp_code),
    .missionary_left(missionary_left), .cannibal_left(cannibal_left),
    .boat_side(boat_side), .move_count(move_count), .finish(finish), .lost(lost)
  );

  mc_move_sequencer #(.MOVE_LIMIT(5'd2)) dut_lim (
    .clock(clock), .reset(reset), .restart(restart),
    .req_valid(req_valid), .req_ready(l_req_ready), .req_m(req_m), .req_c(req_c),
    .resp_valid(l_resp_valid), .resp_code(l_resp_code),
    .missionary_left(l_missionary_left), .cannibal_left(l_cannibal_left),
    .boat_side(l_boat_side), .move_count(l_move_count), .finish(l_finish), .lost(l_lost)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [1:0] m, input logic [1:0] c,
                           input logic b, input logic [4:0] cnt);
    chk({tag, "_m"},    32'(missionary_left), 32'(m));
    chk({tag, "_c"},    32'(cannibal_left),   32'(c));
    chk({tag, "_boat"}, 32'(boat_side),       32'(b));
    chk({tag, "_cnt"},  32'(move_count),      32'(cnt));
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b0; restart = 1'b0; req_valid = 1'b0; req_m = 2'd0; req_c = 2'd0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  // One handshake, then the response must appear exactly in the third cycle.
  task automatic do_move(input string tag, input logic [1:0] m, input logic [1:0] c,
                         input logic [1:0] exp_code);
    @(negedge clock);
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_m = m; req_c = c;
    @(negedge clock);
    req_valid = 1'b0;
    chk({tag, "_rv1"}, 32'(resp_valid), 32'd0);
    @(negedge clock);
    chk({tag, "_rv2"}, 32'(resp_valid), 32'd0);
    @(negedge clock);
    chk({tag, "_rv3"},  32'(resp_valid), 32'd1);
    chk({tag, "_code"}, 32'(resp_code),  32'(exp_code));
    @(negedge clock);
    chk({tag, "_rv4"}, 32'(resp_valid), 32'd0);
  endtask

  logic [1:0] seq_m [11];
  logic [1:0] seq_c [11];
  logic       exp_rv [8];
  int         pulses;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; restart = 1'b0; req_valid = 1'b0; req_m = 2'd0; req_c = 2'd0;
    seq_m = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd1, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0};
    seq_c = '{2'd2, 2'd1, 2'd2, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1, 2'd2, 2'd1, 2'd2};
    exp_rv = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    // Reset values
    apply_reset();
    chk_state("rst", 2'd3, 2'd3, 1'b0, 5'd0);
    chk("rst_rv",     32'(resp_valid), 32'd0);
    chk("rst_code",   32'(resp_code),  32'd0);
    chk("rst_finish", 32'(finish),     32'd0);
    chk("rst_lost",   32'(lost),       32'd0);
    @(negedge clock);
    chk("rst_ready", 32'(req_ready), 32'd1);

    // First legal move
    do_move("mv02", 2'd0, 2'd2, RESP_OK);
    chk_state("mv02", 2'd3, 2'd1, 1'b1, 5'd1);

    // Unsafe and illegal moves leave state unchanged
    apply_reset();
    do_move("uns20", 2'd2, 2'd0, RESP_UNSAFE);
    chk_state("uns20", 2'd3, 2'd3, 1'b0, 5'd0);
    do_move("ill21", 2'd2, 2'd1, RESP_ILLEGAL);
    chk_state("ill21", 2'd3, 2'd3, 1'b0, 5'd0);
    do_move("ill00", 2'd0, 2'd0, RESP_ILLEGAL);
    do_move("uns10", 2'd1, 2'd0, RESP_UNSAFE);
    chk_state("uns10", 2'd3, 2'd3, 1'b0, 5'd0);
    // Boat on right bank with nobody there: requesting anyone is illegal
    do_move("go02", 2'd0, 2'd2, RESP_OK);
    do_move("ill_r10", 2'd1, 2'd0, RESP_ILLEGAL);
    chk_state("ill_r10", 2'd3, 2'd1, 1'b1, 5'd1);

    // Optimal 11-move solution
    apply_reset();
    for (int i = 0; i < 11; i++)
      do_move($sformatf("opt%0d", i), seq_m[i], seq_c[i], (i == 10) ? RESP_WIN : RESP_OK);
    chk_state("win", 2'd0, 2'd0, 1'b1, 5'd11);
    chk("win_finish", 32'(finish),    32'd1);
    chk("win_ready",  32'(req_ready), 32'd0);
    req_valid = 1'b1; req_m = 2'd0; req_c = 2'd1;
    repeat (4) begin
      @(negedge clock);
      chk("done_norv", 32'(resp_valid), 32'd0);
    end
    req_valid = 1'b0;
    chk("done_cnt",    32'(move_count), 32'd11);
    chk("done_finish", 32'(finish),     32'd1);
    restart = 1'b1;
    @(negedge clock);
    restart = 1'b0;
    chk_state("rs_done", 2'd3, 2'd3, 1'b0, 5'd0);
    chk("rs_done_finish", 32'(finish),    32'd0);
    chk("rs_done_ready",  32'(req_ready), 32'd1);

    // Move limit of 2 on the second instance
    apply_reset();
    do_move("lim1", 2'd0, 2'd2, RESP_OK);
    chk("lim1_lost", 32'(l_lost), 32'd0);
    do_move("lim2", 2'd0, 2'd1, RESP_OK);
    chk("lim2_lost",  32'(l_lost),       32'd1);
    chk("lim2_ready", 32'(l_req_ready),  32'd0);
    chk("lim2_cnt",   32'(l_move_count), 32'd2);
    chk("lim2_dflt",  32'(lost),         32'd0);
    req_valid = 1'b1; req_m = 2'd0; req_c = 2'd2;
    repeat (5) begin
      @(negedge clock);
      chk("lost_norv", 32'(l_resp_valid), 32'd0);
    end
    req_valid = 1'b0;
    chk("lost_cnt",  32'(l_move_count), 32'd2);
    chk("lost_hold", 32'(l_lost),       32'd1);

    // Restart in the same cycle as a handshake
    apply_reset();
    do_move("pre_rs", 2'd0, 2'd2, RESP_OK);
    @(negedge clock);
    req_valid = 1'b1; req_m = 2'd0; req_c = 2'd1; restart = 1'b1;
    @(negedge clock);
    req_valid = 1'b0; restart = 1'b0;
    chk_state("rs_hs", 2'd3, 2'd3, 1'b0, 5'd0);
    chk("rs_hs_ready", 32'(req_ready), 32'd1);
    chk("rs_hs_rv0",   32'(resp_valid), 32'd0);
    repeat (4) begin
      @(negedge clock);
      chk("rs_hs_norv", 32'(resp_valid), 32'd0);
    end

    // Reset asserted during CHECK
    do_move("pre_rc", 2'd0, 2'd2, RESP_OK);
    @(negedge clock);
    req_valid = 1'b1; req_m = 2'd0; req_c = 2'd1;
    @(negedge clock);
    req_valid = 1'b0; reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    chk_state("rst_chk", 2'd3, 2'd3, 1'b0, 5'd0);
    chk("rst_chk_rv", 32'(resp_valid), 32'd0);
    repeat (4) begin
      @(negedge clock);
      chk("rst_chk_norv", 32'(resp_valid), 32'd0);
    end
    chk("rst_chk_ready", 32'(req_ready), 32'd1);

    // req_valid held high: back-to-back handshakes only from IDLE
    apply_reset();
    @(negedge clock);
    req_valid = 1'b1; req_m = 2'd0; req_c = 2'd2;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      chk($sformatf("hold_rv%0d", i), 32'(resp_valid), 32'(exp_rv[i]));
      if (resp_valid === 1'b1) pulses++;
    end
    req_valid = 1'b0;
    chk("hold_pulses", 32'(pulses), 32'd2);
    chk_state("hold", 2'd3, 2'd3, 1'b0, 5'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
